// File: rtl/cnn_run_ctrl.sv
// cnn_run_ctrl: image load, core kick, score readback and argmax for the HLS CNN core
module cnn_run_ctrl #(
  parameter int IN_DEPTH  = 784,
  parameter int IN_AW     = 10,
  parameter int OUT_DEPTH = 10,
  parameter int OUT_AW    = 4,
  parameter int DW        = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              run_start,
  output logic              run_busy,
  output logic              run_done,
  input  logic              s_valid,
  input  logic [DW-1:0]     s_data,
  output logic              s_ready,
  output logic              core_start,
  input  logic              core_ready,
  input  logic              core_done,
  output logic              imem_ce,
  output logic              imem_we,
  output logic [IN_AW-1:0]  imem_addr,
  output logic [DW-1:0]     imem_d,
  output logic              omem_ce,
  output logic [OUT_AW-1:0] omem_addr,
  input  logic [DW-1:0]     omem_q,
  output logic              res_valid,
  output logic [DW-1:0]     res_data,
  output logic [OUT_AW-1:0] res_index,
  output logic              res_last,
  output logic [OUT_AW-1:0] class_idx,
  output logic [DW-1:0]     class_score
);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, READ, DONE} state_t;
  state_t r_state, w_next;
  logic [IN_AW-1:0]  r_load_cnt;
  logic [OUT_AW:0]   r_rd_cnt;
  logic [OUT_AW-1:0] w_prev, r_best_idx, w_best_idx;
  logic [DW-1:0]     r_best_score, w_best_score;
  logic              w_acc, w_last_word, w_take;
  // s_ready is gated by reset so a mid-run reset cannot sneak in one more write
  assign run_busy     = r_state != IDLE;
  assign run_done     = r_state == DONE;
  assign s_ready      = r_state == LOAD && !ap_rst;
  assign w_acc        = s_valid && s_ready;
  assign w_last_word  = w_acc && r_load_cnt == IN_AW'(IN_DEPTH - 1);
  assign imem_ce      = w_acc;
  assign imem_we      = w_acc;
  assign imem_addr    = w_acc ? r_load_cnt : '0;
  assign imem_d       = w_acc ? s_data : '0;
  assign core_start   = r_state == KICK;
  assign omem_ce      = r_state == READ && r_rd_cnt < (OUT_AW+1)'(OUT_DEPTH);
  assign omem_addr    = omem_ce ? r_rd_cnt[OUT_AW-1:0] : '0;
  assign w_prev       = OUT_AW'(r_rd_cnt - 1'b1);
  assign res_valid    = r_state == READ && r_rd_cnt != '0;
  assign res_data     = res_valid ? omem_q : '0;
  assign res_index    = res_valid ? w_prev : '0;
  assign res_last     = res_valid && r_rd_cnt == (OUT_AW+1)'(OUT_DEPTH);
  // first beat seeds the best; strict compare keeps the lowest index on ties
  assign w_take       = res_valid && (r_rd_cnt == (OUT_AW+1)'(1) || $signed(omem_q) > $signed(r_best_score));
  assign w_best_score = w_take ? omem_q : r_best_score;
  assign w_best_idx   = w_take ? w_prev : r_best_idx;
  always_ff @(posedge ap_clk) r_state <= ap_rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = run_start ? LOAD : IDLE;
      LOAD:    w_next = w_last_word ? KICK : LOAD;
      KICK:    w_next = !core_ready ? KICK : core_done ? READ : WAIT;
      WAIT:    w_next = core_done ? READ : WAIT;
      READ:    w_next = res_last ? DONE : READ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_load_cnt   <= '0;
      r_rd_cnt     <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      class_idx    <= '0;
      class_score  <= '0;
    end else begin
      r_load_cnt   <= r_state == IDLE ? '0 : w_acc ? r_load_cnt + 1'b1 : r_load_cnt;
      r_rd_cnt     <= r_state == READ ? r_rd_cnt + 1'b1 : '0;
      r_best_score <= w_best_score;
      r_best_idx   <= w_best_idx;
      if (res_last) begin
        class_idx   <= w_best_idx;
        class_score <= w_best_score;
      end
    end
  end
endmodule

// File: tb/tb_cnn_run_ctrl.sv
// tb_cnn_run_ctrl: table-driven runs with image/score scoreboards and a small core model
module tb_cnn_run_ctrl;
  logic ap_clk = 0, ap_rst = 1, run_start = 0, s_valid = 0, core_ready = 0, core_done = 0;
  logic [15:0] s_data = 0, omem_q = 0;
  logic run_busy, run_done, s_ready, core_start, imem_ce, imem_we, omem_ce;
  logic res_valid, res_last;
  logic [9:0] imem_addr;
  logic [15:0] imem_d, res_data, class_score;
  logic [3:0] omem_addr, res_index, class_idx;

  always #5 ap_clk = ~ap_clk;

  cnn_run_ctrl dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .run_start(run_start), .run_busy(run_busy),
    .run_done(run_done), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done),
    .imem_ce(imem_ce), .imem_we(imem_we), .imem_addr(imem_addr), .imem_d(imem_d),
    .omem_ce(omem_ce), .omem_addr(omem_addr), .omem_q(omem_q), .res_valid(res_valid),
    .res_data(res_data), .res_index(res_index), .res_last(res_last),
    .class_idx(class_idx), .class_score(class_score)
  );

  int n_chk = 0, n_fail = 0;
  int n_wr = 0, n_res = 0, n_done = 0;
  logic [25:0] wr_q [$];
  logic [20:0] res_q [$];
  logic [25:0] e_wr;
  logic [20:0] e_res;
  logic [15:0] omem [16];
  logic prev_ready = 0, prev_lastacc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  initial for (int i = 0; i < 16; i++) omem[i] = 16'h0;
  always @(posedge ap_clk) if (omem_ce) omem_q <= omem[omem_addr];

  // core model: ap_ready rdy_lat cycles after start, ap_done done_lat later (or together)
  int rdy_lat = 3, done_lat = 50, cph = 0, ccnt = 0;
  bit same_c = 0;
  initial forever begin
    @(posedge ap_clk); #1;
    core_ready = 0; core_done = 0;
    if (ap_rst) cph = 0;
    else case (cph)
      0: if (core_start) begin cph = 1; ccnt = 0; end
      1: begin
        ccnt++;
        if (ccnt == rdy_lat) begin
          core_ready = 1;
          if (same_c) begin core_done = 1; cph = 0; end
          else begin cph = 2; ccnt = 0; end
        end
      end
      default: begin
        ccnt++;
        if (ccnt == done_lat) begin core_done = 1; cph = 0; end
      end
    endcase
  end

  always @(negedge ap_clk) begin
    if (prev_lastacc) begin
      chk("s_ready_after_last", {31'b0, s_ready}, 0);
      chk("kick_latency", {31'b0, core_start}, 1);
    end
    if (prev_ready) chk("start_drop", {31'b0, core_start}, 0);
    prev_ready = core_ready && core_start;
    prev_lastacc = imem_we && imem_addr == 10'd783;
    if (imem_we || imem_ce) begin
      n_wr++;
      chk("we_ce_in_load", {29'b0, imem_ce, imem_we, s_ready}, 3'b111);
      if (wr_q.size() == 0) chk("unexpected_write", {22'b0, imem_addr}, 32'hFFFF_FFFF);
      else begin
        e_wr = wr_q.pop_front();
        chk("imem_wr", {6'b0, imem_addr, imem_d}, {6'b0, e_wr});
      end
    end
    if (res_valid) begin
      n_res++;
      if (res_q.size() == 0) chk("unexpected_beat", {28'b0, res_index}, 32'hFFFF_FFFF);
      else begin
        e_res = res_q.pop_front();
        chk("res_beat", {11'b0, res_data, res_index, res_last}, {11'b0, e_res});
      end
    end
    if (run_done) n_done++;
  end

  typedef struct {
    logic [9:0][15:0] sc;
    int bubble;
    bit same;
    bit poke;
    logic [3:0] eidx;
    logic [15:0] escore;
  } vec_t;
  vec_t tv [5];
  int raw [5][10] = '{
    '{5, -3, 12, 0, 7, 1, 2, 900, -900, 4},
    '{0, 0, 256, 0, 0, 256, 0, 0, 0, 0},
    '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -1},
    '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7},
    '{100, -32768, 32767, 32767, 0, 0, 0, 0, 0, -1}
  };

  task automatic do_run(input int v);
    int w, budget, w0, r0, d0;
    w0 = n_wr; r0 = n_res; d0 = n_done;
    same_c = tv[v].same;
    for (int i = 0; i < 10; i++) begin
      omem[i] = tv[v].sc[i];
      res_q.push_back({tv[v].sc[i], 4'(i), i == 9});
    end
    run_start = 1; cyc(1); run_start = 0;
    w = 0; budget = 0;
    while (w < 784 && budget < 4000) begin
      s_valid = $urandom_range(99) >= tv[v].bubble;
      s_data = 16'(w * 7 + v);
      if (s_valid && s_ready) begin
        wr_q.push_back({10'(w), s_data});
        w++;
      end
      cyc(1); budget++;
    end
    s_valid = 0;
    chk("load_count", w, 784);
    if (tv[v].poke) begin
      cyc(10); run_start = 1; cyc(1); run_start = 0;
    end
    budget = 0;
    while (n_done == d0 && budget < 3000) begin cyc(1); budget++; end
    chk("class_idx", {28'b0, class_idx}, {28'b0, tv[v].eidx});
    chk("class_score", {16'b0, class_score}, {16'b0, tv[v].escore});
    chk("idle_after_done", {31'b0, run_busy}, 0);
    cyc(3);
    chk("done_pulses", n_done - d0, 1);
    chk("write_count", n_wr - w0, 784);
    chk("beat_count", n_res - r0, 10);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    wr_q.delete(); res_q.delete();
  endtask

  initial begin
    int busy_seen, w0;
    for (int v = 0; v < 5; v++)
      for (int i = 0; i < 10; i++) tv[v].sc[i] = 16'(raw[v][i]);
    tv[0].bubble = 0;  tv[0].same = 0; tv[0].poke = 0; tv[0].eidx = 7; tv[0].escore = 16'h0384;
    tv[1].bubble = 50; tv[1].same = 0; tv[1].poke = 0; tv[1].eidx = 2; tv[1].escore = 16'h0100;
    tv[2].bubble = 0;  tv[2].same = 1; tv[2].poke = 0; tv[2].eidx = 9; tv[2].escore = 16'hFFFF;
    tv[3].bubble = 30; tv[3].same = 0; tv[3].poke = 1; tv[3].eidx = 0; tv[3].escore = 16'hFFF9;
    tv[4].bubble = 10; tv[4].same = 0; tv[4].poke = 0; tv[4].eidx = 2; tv[4].escore = 16'h7FFF;

    ap_rst = 1; cyc(2);
    chk("reset_ctrl", {28'b0, run_busy, run_done, s_ready, core_start}, 0);
    chk("reset_imem", {4'b0, imem_ce, imem_we, imem_addr, imem_d}, 0);
    chk("reset_res", {5'b0, omem_ce, omem_addr, res_valid, res_data, res_index, res_last}, 0);
    chk("reset_class", {12'b0, class_idx, class_score}, 0);
    ap_rst = 0;
    busy_seen = 0;
    repeat (20) begin cyc(1); if (run_busy || s_ready || core_start) busy_seen++; end
    chk("idle_quiet", busy_seen, 0);
    chk("idle_no_writes", n_wr, 0);
    chk("idle_no_beats", n_res, 0);

    for (int v = 0; v < 5; v++) do_run(v);

    // reset mid-load, with s_valid still high through the reset cycle
    w0 = n_wr;
    run_start = 1; cyc(1); run_start = 0;
    for (int w = 0; w < 300; w++) begin
      s_valid = 1; s_data = 16'(w + 16'h4000);
      if (s_ready) wr_q.push_back({10'(w), s_data});
      cyc(1);
    end
    ap_rst = 1; cyc(1); ap_rst = 0; cyc(2);
    s_valid = 0;
    chk("abort_writes", n_wr - w0, 300);
    chk("abort_idle", {30'b0, run_busy, s_ready}, 0);
    chk("abort_q_drained", wr_q.size(), 0);
    wr_q.delete();
    do_run(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
